// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file and its busy-bit scoreboard.
package rf_pkg;
  localparam int unsigned REG_ZERO      = 0;
  localparam int          DEFAULT_XLEN  = 32;
  localparam int          DEFAULT_NREGS = 32;

  typedef logic [$clog2(DEFAULT_NREGS)-1:0] reg_addr_t;
  typedef logic [DEFAULT_XLEN-1:0]          reg_data_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file: read ports, writeback, issue handshake, busy count.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  // Issue handshake: a transfer happens on a rising edge where iss_en && iss_ready && !flush;
  // iss_ready never depends on iss_en, and a refused requester holds iss_addr and retries.
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                iss_ready;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, iss_ready, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, iss_ready, busy_cnt
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on accepted issue, cleared on writeback or flush.
module rf_scoreboard import rf_pkg::*; #(
  parameter  int NREGS = DEFAULT_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic             flush,
  output logic             iss_ready,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt
);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             iss_acc;

  assign iss_ready = (iss_addr == ZERO_ADDR) || !busy_q[iss_addr] ||
                     (wr_en && (wr_addr == iss_addr));
  assign iss_acc   = iss_en && iss_ready && !flush;
  assign busy      = busy_q;

  // Issue is applied after the writeback clear so a same-cycle new producer stays busy.
  always_comb begin
    busy_nxt = busy_q;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)   busy_nxt[wr_addr]  = 1'b0;
      if (iss_acc) busy_nxt[iss_addr] = 1'b1;
    end
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with optional write bypass and busy-bit scoreboard.
module reg_file_sb import rf_pkg::*; #(
  parameter  int XLEN   = DEFAULT_XLEN,
  parameter  int NREGS  = DEFAULT_NREGS,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input logic          clk,
  input logic          reset_n,
  reg_file_sb_if.slave bus
);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    busy;
  logic [NRD*XLEN-1:0] rd_data_c;
  logic [NRD-1:0]      rd_busy_c;
  logic [AW-1:0]       a;
  logic                hit;

  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .iss_en    (bus.iss_en),
    .iss_addr  (bus.iss_addr),
    .flush     (bus.flush),
    .iss_ready (bus.iss_ready),
    .busy      (busy),
    .busy_cnt  (bus.busy_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wr_en && (bus.wr_addr != ZERO_ADDR)) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // x0 reads as zero and never busy; a bypass hit returns the in-flight write and hides busy.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    a         = '0;
    hit       = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a   = bus.rd_addr[i*AW +: AW];
      hit = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == a);
      if (a != ZERO_ADDR) begin
        rd_data_c[i*XLEN +: XLEN] = hit ? bus.wr_data : regs[a];
        rd_busy_c[i]              = busy[a] && !hit;
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypassing and non-bypassing instances driven in lockstep.
module tb_reg_file_sb;
  import rf_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  logic [5:0] exp_q[$];

  reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus1 ();
  reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus0 ();

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );
  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    reg_addr_t ra0;
    reg_addr_t ra1;
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    logic      iss_en;
    reg_addr_t iss_addr;
    logic      flush;
    reg_data_t e_rd0;
    reg_data_t e_rd1;
    logic      e_b0;
    logic      e_b1;
    logic      e_rdy;
    reg_data_t e_nb1;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input int ra0, input int ra1, input bit we, input int wa,
                              input logic [31:0] wd, input bit ie, input int ia, input bit fl,
                              input logic [31:0] r0, input logic [31:0] r1, input bit b0,
                              input bit b1, input bit rdy, input logic [31:0] nb1, input int cnt);
    vec_t v;
    v.ra0 = reg_addr_t'(ra0);   v.ra1 = reg_addr_t'(ra1);
    v.wr_en = we;               v.wr_addr = reg_addr_t'(wa);  v.wr_data = wd;
    v.iss_en = ie;              v.iss_addr = reg_addr_t'(ia); v.flush = fl;
    v.e_rd0 = r0;               v.e_rd1 = r1;
    v.e_b0 = b0;                v.e_b1 = b1;                  v.e_rdy = rdy;
    v.e_nb1 = nb1;              v.e_cnt = 6'(cnt);
    return v;
  endfunction

  // driver tasks
  task automatic drive(input vec_t v);
    bus1.rd_addr = {v.ra1, v.ra0};    bus0.rd_addr = {v.ra1, v.ra0};
    bus1.wr_en = v.wr_en;             bus0.wr_en = v.wr_en;
    bus1.wr_addr = v.wr_addr;         bus0.wr_addr = v.wr_addr;
    bus1.wr_data = v.wr_data;         bus0.wr_data = v.wr_data;
    bus1.iss_en = v.iss_en;           bus0.iss_en = v.iss_en;
    bus1.iss_addr = v.iss_addr;       bus0.iss_addr = v.iss_addr;
    bus1.flush = v.flush;             bus0.flush = v.flush;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 0));
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic scan_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      bus1.rd_addr = {5'(a), 5'(31 - a)};
      bus0.rd_addr = {5'(a), 5'(31 - a)};
      #1;
      check({tag, "_rd0"}, bus1.rd_data[31:0], 32'h0);
      check({tag, "_rd1"}, bus1.rd_data[63:32], 32'h0);
      check({tag, "_busy"}, 32'(bus1.rd_busy), 32'h0);
    end
    check({tag, "_cnt"}, 32'(bus1.busy_cnt), 32'h0);
  endtask

  initial begin
    logic [5:0] ec;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    idle();

    vecs[0]  = mk(0, 5, 0, 0, 32'h0,        0, 0,  0, 32'h0,        32'h0,        0, 0, 1, 32'h0,        0);
    vecs[1]  = mk(1, 2, 1, 5, 32'hDEADBEEF, 0, 0,  0, 32'h0,        32'h0,        0, 0, 1, 32'h0,        0);
    vecs[2]  = mk(5, 0, 1, 0, 32'h00001234, 0, 0,  0, 32'hDEADBEEF, 32'h0,        0, 0, 1, 32'h0,        0);
    vecs[3]  = mk(0, 5, 0, 0, 32'h0,        0, 0,  0, 32'h0,        32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 0);
    vecs[4]  = mk(6, 7, 1, 7, 32'hA5A5A5A5, 0, 0,  0, 32'h0,        32'hA5A5A5A5, 0, 0, 1, 32'h0,        0);
    vecs[5]  = mk(3, 7, 0, 0, 32'h0,        1, 3,  0, 32'h0,        32'hA5A5A5A5, 0, 0, 1, 32'hA5A5A5A5, 1);
    vecs[6]  = mk(3, 0, 0, 0, 32'h0,        1, 3,  0, 32'h0,        32'h0,        1, 0, 0, 32'h0,        1);
    vecs[7]  = mk(3, 3, 1, 3, 32'h00000033, 0, 3,  0, 32'h33,       32'h33,       0, 0, 1, 32'h0,        0);
    vecs[8]  = mk(3, 3, 0, 0, 32'h0,        0, 3,  0, 32'h33,       32'h33,       0, 0, 1, 32'h33,       0);
    vecs[9]  = mk(4, 9, 0, 0, 32'h0,        1, 4,  0, 32'h0,        32'h0,        0, 0, 1, 32'h0,        1);
    vecs[10] = mk(4, 6, 0, 0, 32'h0,        1, 6,  0, 32'h0,        32'h0,        1, 0, 1, 32'h0,        2);
    vecs[11] = mk(6, 9, 0, 0, 32'h0,        1, 9,  0, 32'h0,        32'h0,        1, 0, 1, 32'h0,        3);
    vecs[12] = mk(4, 10, 1, 4, 32'h00000044, 1, 10, 1, 32'h44,      32'h0,        0, 0, 1, 32'h0,        0);
    vecs[13] = mk(4, 10, 0, 0, 32'h0,       0, 9,  0, 32'h44,       32'h0,        0, 0, 1, 32'h0,        0);
    vecs[14] = mk(8, 5, 0, 0, 32'h0,        1, 8,  0, 32'h0,        32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 1);
    vecs[15] = mk(8, 8, 1, 8, 32'h00000088, 1, 8,  0, 32'h88,       32'h88,       0, 0, 1, 32'h0,        1);
    vecs[16] = mk(8, 8, 0, 0, 32'h0,        0, 0,  0, 32'h88,       32'h88,       1, 1, 1, 32'h88,       1);
    vecs[17] = mk(0, 8, 0, 0, 32'h0,        1, 0,  0, 32'h0,        32'h88,       0, 1, 1, 32'h88,       1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_cnt", 32'(bus1.busy_cnt), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    scan_zero("reset_scan");

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_rd0", i),   bus1.rd_data[31:0],  vecs[i].e_rd0);
      check($sformatf("v%0d_rd1", i),   bus1.rd_data[63:32], vecs[i].e_rd1);
      check($sformatf("v%0d_busy0", i), 32'(bus1.rd_busy[0]), 32'(vecs[i].e_b0));
      check($sformatf("v%0d_busy1", i), 32'(bus1.rd_busy[1]), 32'(vecs[i].e_b1));
      check($sformatf("v%0d_ready", i), 32'(bus1.iss_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d_nobyp_rd1", i), bus0.rd_data[63:32], vecs[i].e_nb1);
      exp_q.push_back(vecs[i].e_cnt);
      @(posedge clk);
      #1;
      ec = exp_q.pop_front();
      check($sformatf("v%0d_cnt", i), 32'(bus1.busy_cnt), 32'(ec));
      check($sformatf("v%0d_nobyp_cnt", i), 32'(bus0.busy_cnt), 32'(ec));
    end

    // Non-bypass instance still reports the busy bit during a same-cycle writeback.
    @(negedge clk);
    drive(mk(8, 0, 1, 8, 32'h00000099, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 0));
    #1;
    check("nobyp_busy_hold", 32'(bus0.rd_busy[0]), 32'h1);
    check("nobyp_old_data", bus0.rd_data[31:0], 32'h88);
    check("byp_busy_hidden", 32'(bus1.rd_busy[0]), 32'h0);

    // Asynchronous reset mid-operation, between clock edges, with a write and issue in flight.
    @(negedge clk);
    drive(mk(8, 5, 1, 9, 32'h0000ABCD, 1, 11, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, 0));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_cnt", 32'(bus1.busy_cnt), 32'h0);
    check("async_rd_x8", bus1.rd_data[31:0], 32'h0);
    check("async_rd_x5", bus1.rd_data[63:32], 32'h0);
    check("async_busy", 32'(bus1.rd_busy), 32'h0);
    check("async_nobyp_x5", bus0.rd_data[63:32], 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle();
    reset_n = 1'b1;
    scan_zero("post_reset_scan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
